// File: rtl/ntt_mult_issue.sv
// ntt_mult_issue: registered operand/product issue pipeline for an NTT
// multiplier. Products leave on prod_o toward an external reduction stage of
// fixed latency; reduced values come back on red_res_i and are collected in a
// first-word-fall-through FIFO. Credits (inflight + buffered) keep the FIFO
// from ever overflowing while still allowing one accept per cycle.
module ntt_mult_issue #(
  parameter int                  REG_SIZE    = 23,
  parameter logic [REG_SIZE-1:0] PRIME       = 23'd8380417,
  parameter int                  RED_LATENCY = 4,
  parameter int                  FIFO_DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    zeroize,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [REG_SIZE-1:0]     opa_i,
  input  logic [REG_SIZE-1:0]     opb_i,
  output logic [2*REG_SIZE-1:0]   prod_o,
  input  logic [REG_SIZE-1:0]     red_res_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [REG_SIZE-1:0]     res_o,
  output logic                    busy_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  // Elaboration-time sanity checks on the parameter set.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ntt_mult_issue: FIFO_DEPTH must be a power of two >= 2");
  end
  if (RED_LATENCY < 1) begin : g_bad_latency
    $error("ntt_mult_issue: RED_LATENCY must be >= 1");
  end
  if (PRIME == '0) begin : g_bad_prime
    $error("ntt_mult_issue: PRIME must be non-zero");
  end

  logic                      clear;
  logic                      accept;
  logic                      pop;
  logic                      fifoWr;

  logic [REG_SIZE-1:0]       opa_q;
  logic [REG_SIZE-1:0]       opb_q;
  logic                      v1_q;
  logic [2*REG_SIZE-1:0]     prod_q;
  logic [2*REG_SIZE-1:0]     prodFull;
  logic                      v2_q;
  logic [RED_LATENCY-1:0]    validShift_q;
  logic [RED_LATENCY-1:0]    validShift_d;

  logic [REG_SIZE-1:0]       fifoMem_q [FIFO_DEPTH];
  logic [PW-1:0]             wrPtr_q;
  logic [PW-1:0]             wrPtr_d;
  logic [PW-1:0]             rdPtr_q;
  logic [PW-1:0]             rdPtr_d;
  logic [CW-1:0]             inflight_q;
  logic [CW-1:0]             inflight_d;
  logic [CW-1:0]             count_q;
  logic [CW-1:0]             count_d;

  assign clear       = reset | zeroize;
  assign in_ready_o  = ({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_C;
  assign accept      = in_valid_i & in_ready_o;
  assign out_valid_o = (count_q != '0);
  assign pop         = out_valid_o & out_ready_i;
  assign fifoWr      = validShift_q[RED_LATENCY-1];
  assign res_o       = out_valid_o ? fifoMem_q[rdPtr_q] : '0;
  assign busy_o      = (inflight_q != '0) || (count_q != '0);
  assign prod_o      = prod_q;
  assign prodFull    = {{REG_SIZE{1'b0}}, opa_q} * {{REG_SIZE{1'b0}}, opb_q};

  // Next-state for credit counters, FIFO pointers and the reduction-valid shifter.
  always_comb begin
    inflight_d   = inflight_q;
    count_d      = count_q;
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;
    validShift_d = validShift_q << 1;
    validShift_d[0] = v2_q;

    case ({accept, fifoWr})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    case ({fifoWr, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (fifoWr) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
  end

  // Operand capture, product register and valid pipeline toward the reducer.
  always_ff @(posedge clk) begin
    if (clear) begin
      opa_q        <= '0;
      opb_q        <= '0;
      v1_q         <= 1'b0;
      prod_q       <= '0;
      v2_q         <= 1'b0;
      validShift_q <= '0;
    end else begin
      opa_q        <= accept ? opa_i : '0;
      opb_q        <= accept ? opb_i : '0;
      v1_q         <= accept;
      prod_q       <= v1_q ? prodFull : '0;
      v2_q         <= v1_q;
      validShift_q <= validShift_d;
    end
  end

  // Credit counters and FIFO pointers.
  always_ff @(posedge clk) begin
    if (clear) begin
      inflight_q <= '0;
      count_q    <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
    end
  end

  // Result storage; cleared on reset/zeroize so no stale value is ever visible.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifoMem_q[i] <= '0;
      end
    end else if (fifoWr) begin
      fifoMem_q[wrPtr_q] <= red_res_i;
    end
  end

endmodule

// File: tb/tb_ntt_mult_issue.sv
// Self-checking bench for ntt_mult_issue: models the external reducer as a
// fixed delay of prod_o mod q and checks results against a software scoreboard.
module tb_ntt_mult_issue;

  localparam int         W  = 23;
  localparam logic [W-1:0] Q = 23'd8380417;
  localparam int         RL = 4;
  localparam int         D  = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           zeroize;
  logic           in_valid_i;
  logic           in_ready_o;
  logic [W-1:0]   opa_i;
  logic [W-1:0]   opb_i;
  logic [2*W-1:0] prod_o;
  logic [W-1:0]   red_res_i;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [W-1:0]   res_o;
  logic           busy_o;

  int assertCount = 0;
  int failCount   = 0;
  int accepted;
  int popped;
  logic [W-1:0] expQ [$];
  logic [W-1:0] redPipe [RL];

  ntt_mult_issue #(
    .REG_SIZE   (W),
    .PRIME      (Q),
    .RED_LATENCY(RL),
    .FIFO_DEPTH (D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .zeroize    (zeroize),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .opa_i      (opa_i),
    .opb_i      (opb_i),
    .prod_o     (prod_o),
    .red_res_i  (red_res_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .res_o      (res_o),
    .busy_o     (busy_o)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reducer model: prod_o mod q delayed by RL cycles.
  always @(posedge clk) begin
    redPipe[0] <= W'(prod_o % {{W{1'b0}}, Q});
    for (int i = 1; i < RL; i++) begin
      redPipe[i] <= redPipe[i-1];
    end
  end
  assign red_res_i = redPipe[RL-1];

  // Hard time limit so the run always terminates.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset       = 1'b1;
    zeroize     = 1'b0;
    in_valid_i  = 1'b0;
    opa_i       = '0;
    opb_i       = '0;
    out_ready_i = 1'b0;
    stepCycle();
    stepCycle();
    reset = 1'b0;
    expQ.delete();
    accepted = 0;
    popped   = 0;
  endtask

  // Drive one cycle of stimulus and score any accept/pop that happens in it.
  task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic r);
    in_valid_i  = v;
    opa_i       = a;
    opb_i       = b;
    out_ready_i = r;
    if (out_valid_o && r) begin
      if (expQ.size() == 0) begin
        checkOutput("pop_with_empty_model", 64'(expQ.size()), 64'(1));
      end else begin
        checkOutput("pop_data", 64'(res_o), 64'(expQ.pop_front()));
        popped++;
      end
    end
    if (v && in_ready_o) begin
      expQ.push_back(W'((64'(a) * 64'(b)) % 64'(Q)));
      accepted++;
    end
    stepCycle();
  endtask

  task automatic drainAll();
    for (int k = 0; k < 200 && expQ.size() != 0; k++) begin
      applyStimulus(1'b0, '0, '0, 1'b1);
    end
    checkOutput("drain_empty", 64'(expQ.size()), 64'(0));
    checkOutput("drain_busy", 64'(busy_o), 64'(0));
  endtask

  initial begin
    // Reset values.
    doReset();
    checkOutput("rst_in_ready", 64'(in_ready_o), 64'(1));
    checkOutput("rst_out_valid", 64'(out_valid_o), 64'(0));
    checkOutput("rst_res", 64'(res_o), 64'(0));
    checkOutput("rst_prod", 64'(prod_o), 64'(0));
    checkOutput("rst_busy", 64'(busy_o), 64'(0));

    // Single op (q-1)*(q-1): product in cycle 2, result 1 in cycle 7.
    in_valid_i = 1'b1;
    opa_i      = 23'd8380416;
    opb_i      = 23'd8380416;
    stepCycle();
    in_valid_i = 1'b0;
    opa_i      = '0;
    opb_i      = '0;
    stepCycle();
    checkOutput("single_prod_c2", 64'(prod_o), 64'd70231372333056);
    checkOutput("single_busy_c2", 64'(busy_o), 64'(1));
    for (int c = 2; c < 6; c++) begin
      stepCycle();
    end
    checkOutput("single_valid_c6", 64'(out_valid_o), 64'(0));
    stepCycle();
    checkOutput("single_valid_c7", 64'(out_valid_o), 64'(1));
    checkOutput("single_res_c7", 64'(res_o), 64'(1));
    out_ready_i = 1'b1;
    stepCycle();
    checkOutput("single_valid_after_pop", 64'(out_valid_o), 64'(0));
    checkOutput("single_busy_after_pop", 64'(busy_o), 64'(0));

    // Credit limit: consumer stalled, 10 back-to-back ops, only 8 get in.
    doReset();
    for (int c = 0; c < 16; c++) begin
      checkOutput("credit_ready", 64'(in_ready_o), 64'(c < D));
      applyStimulus(accepted < 10, W'(100 + accepted), W'(200 + accepted), 1'b0);
    end
    checkOutput("credit_accepted", 64'(accepted), 64'(8));
    checkOutput("credit_busy", 64'(busy_o), 64'(1));
    checkOutput("credit_buffered_valid", 64'(out_valid_o), 64'(1));
    checkOutput("credit_head", 64'(res_o), 64'(100 * 200));
    for (int k = 0; k < 100 && popped < 10; k++) begin
      applyStimulus(accepted < 10, W'(100 + accepted), W'(200 + accepted), 1'b1);
    end
    checkOutput("credit_total_accepted", 64'(accepted), 64'(10));
    checkOutput("credit_total_popped", 64'(popped), 64'(10));

    // Full throughput with consumer always ready.
    doReset();
    for (int c = 0; c < 40; c++) begin
      checkOutput("tput_ready", 64'(in_ready_o), 64'(1));
      if (c >= 7) begin
        checkOutput("tput_valid", 64'(out_valid_o), 64'(1));
      end
      applyStimulus(1'b1, W'($urandom_range(8380416)), W'($urandom_range(8380416)), 1'b1);
    end
    drainAll();

    // Random traffic: 1000 ops, 70% valid, 50% ready.
    doReset();
    for (int k = 0; k < 20000 && accepted < 1000; k++) begin
      applyStimulus($urandom_range(99) < 70,
                    (accepted < 1000) ? W'($urandom_range(8380416)) : '0,
                    W'($urandom_range(8380416)),
                    1'($urandom_range(1)));
    end
    checkOutput("rand_accepted", 64'(accepted), 64'(1000));
    drainAll();
    checkOutput("rand_popped", 64'(popped), 64'(1000));

    // Zeroize with three ops in flight; none may ever emerge.
    doReset();
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    opa_i = 23'd5;  opb_i = 23'd7;
    stepCycle();
    opa_i = 23'd11; opb_i = 23'd13;
    stepCycle();
    opa_i = 23'd17; opb_i = 23'd19;
    stepCycle();
    in_valid_i = 1'b0;
    stepCycle();
    zeroize = 1'b1;
    stepCycle();
    zeroize = 1'b0;
    checkOutput("zero_prod", 64'(prod_o), 64'(0));
    checkOutput("zero_res", 64'(res_o), 64'(0));
    checkOutput("zero_out_valid", 64'(out_valid_o), 64'(0));
    checkOutput("zero_busy", 64'(busy_o), 64'(0));
    checkOutput("zero_in_ready", 64'(in_ready_o), 64'(1));
    for (int c = 0; c < 12; c++) begin
      checkOutput("zero_no_result", 64'(out_valid_o), 64'(0));
      stepCycle();
    end
    in_valid_i = 1'b1;
    opa_i = 23'd2;
    opb_i = 23'd3;
    checkOutput("zero_new_ready", 64'(in_ready_o), 64'(1));
    stepCycle();
    in_valid_i = 1'b0;
    for (int c = 1; c < 7; c++) begin
      if (c == 2) begin
        checkOutput("zero_new_prod", 64'(prod_o), 64'(6));
      end
      checkOutput("zero_new_early", 64'(out_valid_o), 64'(0));
      stepCycle();
    end
    checkOutput("zero_new_valid", 64'(out_valid_o), 64'(1));
    checkOutput("zero_new_res", 64'(res_o), 64'(6));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/ntt_mult_issue.md
NTT_MULT_ISSUE -- requirements
Module: ntt_mult_issue

Interface
REQ-001: Parameter REG_SIZE, default 23, coefficient width.
REQ-002: Parameter PRIME, default 23'd8380417, modulus q (bench reference only; no arithmetic uses it).
REQ-003: Parameter RED_LATENCY, default 4, fixed cycles from prod_o change to the matching red_res_i.
REQ-004: Parameter FIFO_DEPTH, default 8, result buffer entries; power of two, >= 2.
REQ-005: clk  input  1  single clock; all state updates on rising edge.
REQ-006: reset  input  1  synchronous, active-high reset.
REQ-007: zeroize  input  1  synchronous clear, same effect as reset.
REQ-008: in_valid_i  input  1  operand pair valid.
REQ-009: in_ready_o  output  1  block can accept an operand pair.
REQ-010: opa_i, opb_i  input  REG_SIZE each  operands, each < q.
REQ-011: prod_o  output  2*REG_SIZE  registered product driven to the reduction stage.
REQ-012: red_res_i  input  REG_SIZE  reduced result returned by the reduction stage.
REQ-013: out_valid_o  output  1  res_o holds a valid result.
REQ-014: out_ready_i  input  1  consumer accepts res_o.
REQ-015: res_o  output  REG_SIZE  reduced product, FIFO head.
REQ-016: busy_o  output  1  any result in flight or buffered.

Function
REQ-017: Accept occurs when in_valid_i and in_ready_o are both high in a cycle; pop occurs when out_valid_o and out_ready_i are both high.
REQ-018: Stage 1: on accept, opa_i/opb_i are registered with valid v1; with no accept, v1 = 0 and operand registers load 0.
REQ-019: Stage 2: prod_o <= opa_f*opb_f (full 46-bit, unsigned, no truncation) with valid v2; prod_o = 0 when v1 = 0.
REQ-020: A RED_LATENCY-deep valid shift register follows v2; when its tail is high, red_res_i is written into the FIFO at that edge.
REQ-021: Latency: accept in cycle 0 -> prod_o valid in cycle 2 -> FIFO write at end of cycle 2+RED_LATENCY -> out_valid_o high in cycle 3+RED_LATENCY (7 with defaults).
REQ-022: The FIFO is first-word fall-through: out_valid_o = not empty, res_o = head entry; res_o = 0 when empty.
REQ-023: Result order equals accept order; no reordering or dropping.
REQ-024: inflight counter: +1 on accept, -1 on FIFO write; both in one cycle leaves it unchanged.
REQ-025: count counter: +1 on write, -1 on pop; both in one cycle leaves it unchanged.
REQ-026: Credit rule: in_ready_o = (inflight + count < FIFO_DEPTH), computed from registered counters only (no combinational path from out_ready_i).
REQ-027: FIFO write with FIFO full never occurs; write and pop with FIFO full in one cycle are legal.
REQ-028: Read/write pointers wrap modulo FIFO_DEPTH.
REQ-029: With out_ready_i held high and defaults, sustained throughput is 1 accept per cycle.
REQ-030: busy_o = (inflight != 0) or (count != 0).
REQ-031: in_valid_i while in_ready_o is low is ignored; operands need not be held.

Reset
REQ-032: On reset or zeroize: v1, v2, shift register, pointers, counters, operand registers, prod_o, FIFO storage all clear to 0.
REQ-033: Output values during/after reset: in_ready_o = 1, out_valid_o = 0, res_o = 0, prod_o = 0, busy_o = 0.
REQ-034: Reset or zeroize mid-operation discards all in-flight and buffered results; the first accept afterwards follows REQ-021 timing exactly.

Verification
REQ-035: Bench models reduction as a RED_LATENCY-cycle delay of prod_o mod q.
REQ-036: Single op a=8380416, b=8380416 -> prod_o = 70231372333056 in cycle 2, res_o = 1 with out_valid_o high in cycle 7.
REQ-037: out_ready_i low, 10 back-to-back ops -> exactly 8 accepted, in_ready_o low from cycle 8 on, busy_o high; raise out_ready_i -> 8 results pop in order, then remaining 2 are accepted.
REQ-038: 1000 random ops, out_ready_i random 50%, in_valid_i random 70% -> all results equal (a*b) mod q in order, no overflow, no loss.
REQ-039: out_ready_i held high, continuous in_valid_i -> in_ready_o never drops after reset; one result per cycle from cycle 7.
REQ-040: zeroize asserted in cycle 4 with 3 ops in flight -> all outputs 0 the next cycle, no result ever emerges for those ops; new op a=2,b=3 -> res_o = 6, 7 cycles after its accept.
